// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects the next control address (JMP/CALL/RET/MAP).
// Define MSEQ_STACK_EN for a STACK_DEPTH-deep return stack with a sticky sbr_err flag.
module micro_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int RESET_ADDR  = 64,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        cd,
  input  logic [1:0]        br,
  input  logic [ADDR_W-1:0] ad,
  input  logic [3:0]        opcode,
  input  logic              cond_i,
  input  logic              cond_s,
  input  logic              cond_z,
  output logic [ADDR_W-1:0] car,
  output logic              sbr_err
);

  typedef enum logic [1:0] {
    BR_JMP  = 2'b00,
    BR_CALL = 2'b01,
    BR_RET  = 2'b10,
    BR_MAP  = 2'b11
  } br_e;

  localparam logic [ADDR_W-1:0] RST_CAR = ADDR_W'(RESET_ADDR);

  logic              cond;
  logic              push;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] map_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] car_nxt;
  logic [31:0]       map_full;

  assign inc      = car + ADDR_W'(1);
  // Opcode indexes 4-word routines; widen first so any ADDR_W truncates cleanly.
  assign map_full = {26'd0, opcode, 2'b00};
  assign map_addr = map_full[ADDR_W-1:0];

  always_comb begin
    cond = 1'b1;
    case (cd)
      2'b00:   cond = 1'b1;
      2'b01:   cond = cond_i;
      2'b10:   cond = cond_s;
      default: cond = cond_z;
    endcase
  end

  always_comb begin
    car_nxt = inc;
    push    = 1'b0;
    case (br)
      BR_JMP: begin
        if (cond) car_nxt = ad;
      end
      BR_CALL: begin
        if (cond) begin
          car_nxt = ad;
          push    = 1'b1;
        end
      end
      BR_RET:  car_nxt = ret_addr;
      BR_MAP:  car_nxt = map_addr;
      default: car_nxt = inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      car <= RST_CAR;
    end else if (en) begin
      car <= car_nxt;
    end
  end

`ifdef MSEQ_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              call_full;
  logic              ret_empty;
  logic              err_set;
  logic              err_q;

  assign sp_dec    = sp - SP_W'(1);
  assign push_idx  = sp[IDX_W-1:0];
  assign pop_idx   = sp_dec[IDX_W-1:0];
  assign call_full = (sp == SP_W'(STACK_DEPTH));
  assign ret_empty = (sp == '0);
  // Underflow restarts the fetch routine rather than jumping to stale data.
  assign ret_addr  = ret_empty ? RST_CAR : stack[pop_idx];
  assign err_set   = (push && call_full) || ((br == BR_RET) && ret_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (en) begin
      if (push && !call_full) begin
        stack[push_idx] <= inc;
        sp              <= sp + SP_W'(1);
      end else if ((br == BR_RET) && !ret_empty) begin
        sp <= sp_dec;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign sbr_err = err_q;
`else
  logic [ADDR_W-1:0] sbr;

  assign ret_addr = sbr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sbr <= '0;
    end else if (en && push) begin
      sbr <= inc;
    end
  end

  assign sbr_err = 1'b0;
`endif

endmodule
